sram_controller: RTL
====================

// Module: sram_controller
// PURPOSE
// - Multi-cycle bridge between MemStage and an external 16-bit asynchronous SRAM.
// - Splits each 32-bit data-memory access into two 16-bit SRAM transactions (low half first).
// - Drops ready while busy so HazardDetectionUnit/pipeline registers freeze the core.
// - Sits directly downstream of MemStage; read_data feeds MemReg.
// PARAMETERS
// - BASE_ADDR    1024  byte address mapped to SRAM word 0
// - SRAM_ADDR_W  18    SRAM halfword address width
// - WAIT_CYCLES  2     extra cycles held per 16-bit access (phase length = WAIT_CYCLES+1)
// PORTS
// - clk          in   1   single clock, rising edge
// - rst          in   1   asynchronous, active-low reset
// - rd_en        in   1   read request from MemStage (level, held while ready=0)
// - wr_en        in   1   write request from MemStage (level, held while ready=0)
// - address      in   32  byte address
// - write_data   in   32  store data
// - read_data    out  32  load data, registered
// - ready        out  1   0 = stall pipeline; 1 = idle or access complete this cycle
// - sram_addr    out  SRAM_ADDR_W  halfword address
// - sram_we_n    out  1   SRAM write enable, active-low
// - sram_dq_out  out  16  write data to SRAM
// - sram_dq_oe   out  1   1 = drive sram_dq_out onto the pad
// - sram_dq_in   in   16  read data from SRAM
// BEHAVIOUR
// - States: IDLE, LOW, HIGH, DONE; 2-bit wait counter cnt.
// - rst low (any time, mid-access included): state=IDLE, cnt=0, read_data=0; any write in progress is abandoned.
// - Outputs in IDLE and DONE: sram_we_n=1, sram_dq_oe=0, sram_addr=0.
// - req = rd_en | wr_en. If both are set, the access is a write.
// - IDLE: if req, latch op, waddr=(address-BASE_ADDR)>>2 (unsigned, truncated; wraps), and write_data; go to LOW with cnt=0.
// - LOW: sram_addr={waddr,1'b0}; hold while cnt<WAIT_CYCLES (cnt++); at cnt==WAIT_CYCLES go to HIGH with cnt=0.
//   - On a read, sample sram_dq_in into read_data[15:0] on that last cycle.
// - HIGH: sram_addr={waddr,1'b1}; identical timing to LOW.
//   - On a read, the last cycle samples into read_data[31:16]. HIGH then goes to DONE.
// - Write phases (LOW/HIGH): sram_we_n=0 and sram_dq_oe=1 for the whole phase.
//   - sram_dq_out = wdata[15:0] in LOW and wdata[31:16] in HIGH.
// - Read phases: sram_we_n=1 and sram_dq_oe=0.
// - DONE: lasts one cycle, then IDLE.
// - ready is combinational:
//   - 1 in DONE;
//   - 1 in IDLE with req=0;
//   - 0 in IDLE with req=1, so the pipeline freezes the same cycle the request appears;
//   - 0 in LOW and HIGH.
// - Latency: request first seen in cycle 0 gives ready=1 in cycle 2*WAIT_CYCLES+3 (cycle 7 at default).
// - Back-to-back: the pipeline advances at the DONE edge. A request present in the following IDLE cycle starts immediately.
//   - Minimum one IDLE cycle (ready=0) between accesses.
// - Inputs are ignored outside IDLE; address/data changes mid-access do not affect the access in flight.
// - read_data holds its last value across writes and idle; it only changes on read phase sampling.
// TESTING
// - Reset: rst=0 with rd_en=wr_en=0 -> read_data=0, ready=1, sram_we_n=1, sram_dq_oe=0.
// - Write: wr_en=1, address=1028, write_data=32'hDEADBEEF.
//   - Cycles 1-3: sram_addr=2, dq_out=16'hBEEF, we_n=0.
//   - Cycles 4-6: sram_addr=3, dq_out=16'hDEAD.
//   - ready=1 only in cycles 0? no (0) and 7.
// - Read: rd_en=1, address=1028, SRAM model returns 16'hBEEF @2 and 16'hDEAD @3 -> read_data=32'hDEADBEEF with ready=1 at cycle 7.
// - Priority and wrap:
//   - rd_en=wr_en=1 -> write performed, read_data unchanged.
//   - address=1020 -> waddr wraps to all-ones truncated, sram_addr={18'h3FFFF&..,0}.
// - Reset mid-access: drop rst in HIGH of a write -> sram_we_n=1, dq_oe=0, state IDLE immediately.
//   - After release, a read completes normally in 7 cycles.
// - Back-to-back reads at 1024 then 1032: first ready at cycle 7, IDLE cycle 8 with ready=0, second ready at cycle 15.

Source files
------------

// File: rtl/sram_controller_if.sv
// Bundles the MemStage-side request/response signals and the SRAM pad signals.
// The slave modport is the controller view; the master modport is the pipeline plus SRAM side.
interface sram_controller_if #(
    parameter int SRAM_ADDR_W = 18
);
    logic                   rd_en;
    logic                   wr_en;
    logic [31:0]            address;
    logic [31:0]            write_data;
    logic [31:0]            read_data;
    logic                   ready;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic                   sram_we_n;
    logic [15:0]            sram_dq_out;
    logic                   sram_dq_oe;
    logic [15:0]            sram_dq_in;

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
    );

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
    );
endinterface

// File: rtl/sram_controller.sv
// Bridges 32-bit MemStage accesses onto a 16-bit asynchronous SRAM as two
// halfword phases (low then high), holding ready low until the access completes.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_ADDR_W = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input logic          clk,
    input logic          rst,
    sram_controller_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] LAST_CNT = 2'(WAIT_CYCLES);

    logic [1:0]             state;
    logic [1:0]             cnt;
    logic                   op_wr;
    logic [SRAM_ADDR_W-2:0] waddr;
    logic [31:0]            wdata;
    logic [31:0]            rdata;
    logic                   req;
    logic                   last;

    always_comb begin
        req  = bus.rd_en | bus.wr_en;
        last = (cnt == LAST_CNT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_wr <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // Write wins when both enables are set.
                        op_wr <= bus.wr_en;
                        waddr <= (SRAM_ADDR_W-1)'((bus.address - BASE_ADDR) >> 2);
                        wdata <= bus.write_data;
                        cnt   <= '0;
                        state <= LOW;
                    end
                end
                LOW: begin
                    if (last) begin
                        cnt   <= '0;
                        state <= HIGH;
                        if (!op_wr)
                            rdata[15:0] <= bus.sram_dq_in;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                HIGH: begin
                    if (last) begin
                        cnt   <= '0;
                        state <= DONE;
                        if (!op_wr)
                            rdata[31:16] <= bus.sram_dq_in;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.sram_addr   = '0;
        bus.sram_we_n   = 1'b1;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_dq_out = '0;
        case (state)
            LOW: begin
                bus.sram_addr = {waddr, 1'b0};
                if (op_wr) begin
                    bus.sram_we_n   = 1'b0;
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_dq_out = wdata[15:0];
                end
            end
            HIGH: begin
                bus.sram_addr = {waddr, 1'b1};
                if (op_wr) begin
                    bus.sram_we_n   = 1'b0;
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_dq_out = wdata[31:16];
                end
            end
            default: ;
        endcase
        // Freeze the pipeline in the same cycle a request first appears.
        bus.ready = (state == DONE) || ((state == IDLE) && !req);
    end

    assign bus.read_data = rdata;
endmodule
